// File: rtl/vertex_gather.sv
// vertex_gather: assembles a serial stream of 16-bit coordinates into a
// four-vertex frame (v1X,v1Y,v1Z ... v4Z) and presents it on registered
// parallel buses. Fill and output banks are double-buffered so the next
// frame can fill while the current one waits for the downstream stage.
//
// state | meaning
// HUNT  | waiting for a frame-start word; other words are dropped
// FILL  | storing words into the fill bank at slot idx
// FULL  | fill bank complete, waiting for the output bank to free up
module vertex_gather (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_first,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] vtx1_X_raw,
  output logic [15:0] vtx1_Y_raw,
  output logic [15:0] vtx1_Z_raw,
  output logic [15:0] vtx2_X_raw,
  output logic [15:0] vtx2_Y_raw,
  output logic [15:0] vtx2_Z_raw,
  output logic [15:0] vtx3_X_raw,
  output logic [15:0] vtx3_Y_raw,
  output logic [15:0] vtx3_Z_raw,
  output logic [15:0] vtx4_X_raw,
  output logic [15:0] vtx4_Y_raw,
  output logic [15:0] vtx4_Z_raw,
  output logic        frame_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {S_HUNT, S_FILL, S_FULL} state_t;

  localparam logic [3:0] LAST_SLOT = 4'd11;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic [15:0] r_fill [12];
  logic [15:0] r_out  [12];
  logic [15:0] w_xfer_data [12];
  logic        r_out_valid;
  logic        r_frame_err;
  logic [7:0]  r_frame_cnt;

  logic        w_accept;
  logic        w_out_free;
  logic        w_store;
  logic [3:0]  w_slot;
  logic        w_resync;
  logic        w_xfer;
  logic        w_xfer_live;

  // in_ready depends only on state (and is held low during reset)
  assign in_ready   = rst_n && (r_state != S_FULL);
  assign w_accept   = in_valid && in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Next-state, fill-slot selection and transfer decision
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_store     = 1'b0;
    w_slot      = r_idx;
    w_resync    = 1'b0;
    w_xfer      = 1'b0;
    w_xfer_live = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_accept && in_first) begin
          w_store     = 1'b1;
          w_slot      = 4'd0;
          w_idx_nxt   = 4'd1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (w_accept) begin
          w_store = 1'b1;
          if (in_first) begin
            // frame start mid-fill: abandon the partial frame and restart
            w_resync  = 1'b1;
            w_slot    = 4'd0;
            w_idx_nxt = 4'd1;
          end else if (r_idx == LAST_SLOT) begin
            w_idx_nxt = 4'd0;
            if (w_out_free) begin
              w_xfer      = 1'b1;
              w_xfer_live = 1'b1;
              w_state_nxt = S_HUNT;
            end else begin
              w_state_nxt = S_FULL;
            end
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      S_FULL: begin
        if (w_out_free) begin
          w_xfer      = 1'b1;
          w_state_nxt = S_HUNT;
        end
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // Transfer source: the fill bank, with slot 11 bypassed from the input
  // when the frame completes and transfers on the same edge
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      w_xfer_data[i] = r_fill[i];
    end
    if (w_xfer_live) begin
      w_xfer_data[11] = in_data;
    end
  end

  // State and slot index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Fill bank write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 12; i++) begin
        r_fill[i] <= 16'd0;
      end
    end else if (w_store) begin
      r_fill[w_slot] <= in_data;
    end
  end

  // Output bank, valid flag and frame counter; a transfer wins over a present
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 12; i++) begin
        r_out[i] <= 16'd0;
      end
      r_out_valid <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else if (w_xfer) begin
      for (int i = 0; i < 12; i++) begin
        r_out[i] <= w_xfer_data[i];
      end
      r_out_valid <= 1'b1;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Resync error pulse, high for the cycle after the resync edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_resync;
    end
  end

  assign out_valid  = r_out_valid;
  assign frame_err  = r_frame_err;
  assign frame_cnt  = r_frame_cnt;
  assign vtx1_X_raw = r_out[0];
  assign vtx1_Y_raw = r_out[1];
  assign vtx1_Z_raw = r_out[2];
  assign vtx2_X_raw = r_out[3];
  assign vtx2_Y_raw = r_out[4];
  assign vtx2_Z_raw = r_out[5];
  assign vtx3_X_raw = r_out[6];
  assign vtx3_Y_raw = r_out[7];
  assign vtx3_Z_raw = r_out[8];
  assign vtx4_X_raw = r_out[9];
  assign vtx4_Y_raw = r_out[10];
  assign vtx4_Z_raw = r_out[11];

endmodule

// File: tb/tb_vertex_gather.sv
// tb_vertex_gather: directed scenarios followed by random traffic, each cycle
// compared against a frame-level reference model built from word queues.
module tb_vertex_gather;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_first;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] vtx1_X_raw, vtx1_Y_raw, vtx1_Z_raw;
  logic [15:0] vtx2_X_raw, vtx2_Y_raw, vtx2_Z_raw;
  logic [15:0] vtx3_X_raw, vtx3_Y_raw, vtx3_Z_raw;
  logic [15:0] vtx4_X_raw, vtx4_Y_raw, vtx4_Z_raw;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  logic [15:0] bus [12];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [15:0] m_part [$];
  bit          m_hunting;
  bit          m_pend_valid;
  logic [15:0] m_pend [12];
  bit          m_out_valid;
  logic [15:0] m_out [12];
  logic [7:0]  m_cnt;
  bit          m_err;

  vertex_gather dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready),
    .vtx1_X_raw(vtx1_X_raw), .vtx1_Y_raw(vtx1_Y_raw), .vtx1_Z_raw(vtx1_Z_raw),
    .vtx2_X_raw(vtx2_X_raw), .vtx2_Y_raw(vtx2_Y_raw), .vtx2_Z_raw(vtx2_Z_raw),
    .vtx3_X_raw(vtx3_X_raw), .vtx3_Y_raw(vtx3_Y_raw), .vtx3_Z_raw(vtx3_Z_raw),
    .vtx4_X_raw(vtx4_X_raw), .vtx4_Y_raw(vtx4_Y_raw), .vtx4_Z_raw(vtx4_Z_raw),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  assign bus[0]  = vtx1_X_raw;
  assign bus[1]  = vtx1_Y_raw;
  assign bus[2]  = vtx1_Z_raw;
  assign bus[3]  = vtx2_X_raw;
  assign bus[4]  = vtx2_Y_raw;
  assign bus[5]  = vtx2_Z_raw;
  assign bus[6]  = vtx3_X_raw;
  assign bus[7]  = vtx3_Y_raw;
  assign bus[8]  = vtx3_Z_raw;
  assign bus[9]  = vtx4_X_raw;
  assign bus[10] = vtx4_Y_raw;
  assign bus[11] = vtx4_Z_raw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: words collect in a queue; a complete frame either moves
  // straight to the output or waits as pending until the output is free.
  task automatic model_tick(input bit rst, input bit v, input bit f,
                            input logic [15:0] d, input bit ordy);
    bit          free;
    bit          xfer;
    bit          acc;
    logic [15:0] nout [12];
    if (!rst) begin
      m_part.delete();
      m_hunting    = 1'b1;
      m_pend_valid = 1'b0;
      m_out_valid  = 1'b0;
      for (int i = 0; i < 12; i++) m_out[i] = 16'd0;
      m_cnt = 8'd0;
      m_err = 1'b0;
      return;
    end
    free  = !m_out_valid || ordy;
    xfer  = 1'b0;
    acc   = v && !m_pend_valid;
    m_err = 1'b0;
    for (int i = 0; i < 12; i++) nout[i] = 16'd0;
    if (m_pend_valid && free) begin
      xfer         = 1'b1;
      nout         = m_pend;
      m_pend_valid = 1'b0;
    end else if (acc) begin
      if (f) begin
        if (!m_hunting) m_err = 1'b1;
        m_part.delete();
        m_part.push_back(d);
        m_hunting = 1'b0;
      end else if (!m_hunting) begin
        m_part.push_back(d);
        if (m_part.size() == 12) begin
          for (int i = 0; i < 12; i++) nout[i] = m_part[i];
          if (free) begin
            xfer = 1'b1;
          end else begin
            m_pend       = nout;
            m_pend_valid = 1'b1;
          end
          m_part.delete();
          m_hunting = 1'b1;
        end
      end
    end
    if (xfer) begin
      m_out       = nout;
      m_out_valid = 1'b1;
      m_cnt       = m_cnt + 8'd1;
    end else if (m_out_valid && ordy) begin
      m_out_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_out_valid);
    chk("frame_err", frame_err, m_err);
    chk("frame_cnt", frame_cnt, m_cnt);
    for (int i = 0; i < 12; i++) chk($sformatf("bus%0d", i), bus[i], m_out[i]);
  endtask

  // one clock cycle: drive inputs, check in_ready combinationally, clock, check outputs
  task automatic step(input bit rst, input bit v, input bit f,
                      input logic [15:0] d, input bit ordy);
    rst_n     = rst;
    in_valid  = v;
    in_first  = f;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (!rst) chk("in_ready_rst", in_ready, 1'b0);
    else      chk("in_ready", in_ready, !m_pend_valid);
    model_tick(rst, v, f, d, ordy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_frame(input logic [15:0] base, input bit ordy);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, i == 0, base + 16'(i), ordy);
  endtask

  initial begin
    int k;
    bit f;
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b0;
    model_tick(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;

    // reset held with traffic present
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("ready_after_release", in_ready, 1'b1);

    // nominal frame 1..12
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, i == 1, 16'(i), 1'b1);
    chk("nom_out_valid", out_valid, 1'b1);
    chk("nom_v1x", vtx1_X_raw, 16'd1);
    chk("nom_v4z", vtx4_Z_raw, 16'd12);
    chk("nom_cnt", frame_cnt, 8'd1);

    // negative values -1..-12
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, i == 1, 16'(-i), 1'b1);
    chk("neg_v2x", vtx2_X_raw, 16'hFFFC);
    chk("neg_v4z", vtx4_Z_raw, 16'hFFF4);
    chk("neg_cnt", frame_cnt, 8'd2);

    // backpressure: A delivered, B fills while A is held
    send_frame(16'd100, 1'b1);
    send_frame(16'd200, 1'b0);
    chk("bp_ready_full", in_ready, 1'b0);
    chk("bp_hold_a", vtx1_X_raw, 16'd100);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("bp_still_a", vtx4_Z_raw, 16'd111);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("bp_b_v1x", vtx1_X_raw, 16'd200);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_cnt", frame_cnt, 8'd4);
    chk("bp_ready_back", in_ready, 1'b1);

    // resync after 5 words
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 16'd300 + 16'(i), 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'd400, 1'b1);
    chk("rs_err_pulse", frame_err, 1'b1);
    for (int i = 1; i < 12; i++) step(1'b1, 1'b1, 1'b0, 16'd400 + 16'(i), 1'b1);
    chk("rs_v1x", vtx1_X_raw, 16'd400);
    chk("rs_v4z", vtx4_Z_raw, 16'd411);
    chk("rs_cnt", frame_cnt, 8'd5);

    // hunt drop after a reset
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'd50 + 16'(i), 1'b1);
    chk("hd_no_valid", out_valid, 1'b0);
    send_frame(16'd500, 1'b1);
    chk("hd_v1x", vtx1_X_raw, 16'd500);
    chk("hd_v2y", vtx2_Y_raw, 16'd504);
    chk("hd_cnt", frame_cnt, 8'd1);

    // mid-fill reset discards everything
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i == 0, 16'd600 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_bus", vtx1_X_raw, 16'd0);

    // counter wrap over 256 frames
    for (int n = 0; n < 255; n++) send_frame(16'($urandom), 1'b1);
    chk("wrap_255", frame_cnt, 8'd255);
    send_frame(16'($urandom), 1'b1);
    chk("wrap_0", frame_cnt, 8'd0);

    // random traffic
    k = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        step(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        k = 0;
      end else begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        f = (k % 12 == 0) || ($urandom_range(0, 39) == 0);
        if (v && !m_pend_valid) k = f ? 1 : k + 1;
        step(1'b1, v, f, 16'($urandom), $urandom_range(0, 2) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
